// File: rtl/inst_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_prefetch : byte-loadable instruction memory, fetch PC and prefetch  |
// |                 queue with valid/ready output and single-cycle flush.    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module inst_prefetch #(
  parameter int XLEN       = 32,
  parameter int IMEM_WORDS = 32,
  parameter int QDEPTH     = 4,
  parameter int PC_W       = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [$clog2(IMEM_WORDS*XLEN/8)-1:0]   load_addr,
  input  logic [7:0]                             load_data,
  input  logic                                   load_we,
  input  logic                                   redirect,
  input  logic [PC_W-1:0]                        redirect_pc,
  output logic                                   inst_valid,
  input  logic                                   inst_ready,
  output logic [XLEN-1:0]                        inst_out,
  output logic [PC_W-1:0]                        inst_pc,
  output logic [$clog2(QDEPTH):0]                queue_level
);

  localparam int BYTES = XLEN / 8;
  localparam int LA_W  = $clog2(IMEM_WORDS * BYTES);
  localparam int IDX_W = $clog2(IMEM_WORDS);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [IMEM_WORDS];
  logic [XLEN-1:0]  rd_data_q;
  logic [XLEN-1:0]  q_inst_q [QDEPTH];
  logic [PC_W-1:0]  q_pc_q [QDEPTH];

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rd_pc_q, rd_pc_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             flush, issue, push, pop;
  logic [IDX_W-1:0] load_word;
  logic [LA_W-1:0]  load_lane;

  assign load_word = IDX_W'(load_addr / LA_W'(BYTES));
  assign load_lane = load_addr % LA_W'(BYTES);

  // Read uses the pre-edge array, so a same-word write returns old data.
  always_ff @(posedge clk) begin
    if (load_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (load_lane == LA_W'(b)) begin
          mem[load_word][b*8 +: 8] <= load_data;
        end
      end
    end
    rd_data_q <= mem[fetch_pc_q[IDX_W-1:0]];
  end

  always_comb begin
    flush      = load_we | redirect;
    // Credit counts the in-flight read so its push always finds a free slot.
    issue      = !flush &&
                 (({1'b0, count_q} + (CNT_W+1)'(rd_valid_q)) < (CNT_W+1)'(QDEPTH));
    push       = rd_valid_q && !flush;
    pop        = (count_q != '0) && inst_ready && !flush;
    fetch_pc_d = fetch_pc_q;
    rd_pc_d    = rd_pc_q;
    rd_valid_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = load_we ? '0 : redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        rd_pc_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
      rd_pc_q    <= '0;
      rd_valid_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_valid_q <= rd_valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entries are cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else if (push) begin
      q_inst_q[tail_q] <= rd_data_q;
      q_pc_q[tail_q]   <= rd_pc_q;
    end
  end

  assign inst_valid  = (count_q != '0);
  assign inst_out    = q_inst_q[head_q];
  assign inst_pc     = q_pc_q[head_q];
  assign queue_level = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_prefetch : vectors, directed corner cases and a random run      |
// |                    against a queue-based reference model.                |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_inst_prefetch;

  localparam int XLEN = 32, IMEM_WORDS = 32, QDEPTH = 4, PC_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_we;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  queue_level;

  int errors = 0;
  int checks = 0;

  inst_prefetch #(.XLEN(XLEN), .IMEM_WORDS(IMEM_WORDS), .QDEPTH(QDEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_addr(load_addr), .load_data(load_data),
    .load_we(load_we), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .queue_level(queue_level)
  );

  always #5 clk = ~clk;

  // Reference model: byte memory, one pending read, and a queue of fetched words.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [7:0]  m_bytes [128];
  bit          m_rdv;
  logic [31:0] m_rdpc, m_rdata, m_fetch;

  function automatic logic [31:0] mword(int idx);
    return {m_bytes[idx*4+3], m_bytes[idx*4+2], m_bytes[idx*4+1], m_bytes[idx*4]};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdv   = 1'b0;
    m_fetch = '0;
  endtask

  task automatic model_step(bit we, bit rd, bit rdy, logic [31:0] rpc,
                            logic [6:0] addr, logic [7:0] data);
    int n = mq.size();
    if (we || rd) begin
      mq.delete();
      m_rdv   = 1'b0;
      m_fetch = we ? 32'd0 : rpc;
      if (we) m_bytes[addr] = data;
    end else begin
      if (n != 0 && rdy) void'(mq.pop_front());
      if (m_rdv) mq.push_back('{m_rdata, m_rdpc});
      if (n + int'(m_rdv) < QDEPTH) begin
        m_rdv   = 1'b1;
        m_rdpc  = m_fetch;
        m_rdata = mword(int'(m_fetch % IMEM_WORDS));
        m_fetch = m_fetch + 1;
      end else begin
        m_rdv = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    chk("model_valid", inst_valid, mq.size() != 0);
    chk("model_level", queue_level, mq.size());
    if (mq.size() != 0) begin
      chk("model_inst", inst_out, mq[0].inst);
      chk("model_pc", inst_pc, mq[0].pc);
    end
  endtask

  // One clock edge: the model sees the inputs that were applied before it.
  task automatic tick();
    bit          c_we  = load_we;
    bit          c_rd  = redirect;
    bit          c_rdy = inst_ready;
    bit          c_rst = rst_n;
    logic [31:0] c_rpc = redirect_pc;
    logic [6:0]  c_adr = load_addr;
    logic [7:0]  c_dat = load_data;
    @(posedge clk);
    if (c_rst) model_step(c_we, c_rd, c_rdy, c_rpc, c_adr, c_dat);
    #1;
    model_check();
  endtask

  task automatic load_word(int idx, logic [31:0] val);
    load_we = 1'b1;
    for (int b = 0; b < 4; b++) begin
      load_addr = 7'(idx * 4 + b);
      load_data = val[b*8 +: 8];
      tick();
    end
    load_we = 1'b0;
  endtask

  typedef struct {
    bit          rdr;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    int          elvl;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[16];

  initial begin
    // Fill, saturate, drain, then redirect to 5 while three entries are held.
    tbl[0]  = '{0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 2, 0};
    tbl[3]  = '{0, 0, 0, 1, 3, 0};
    tbl[4]  = '{0, 0, 0, 1, 4, 0};
    tbl[5]  = '{0, 0, 0, 1, 4, 0};
    tbl[6]  = '{0, 0, 0, 1, 4, 0};
    tbl[7]  = '{0, 0, 1, 1, 3, 1};
    tbl[8]  = '{0, 0, 1, 1, 2, 2};
    tbl[9]  = '{0, 0, 1, 1, 2, 3};
    tbl[10] = '{0, 0, 0, 1, 3, 3};
    tbl[11] = '{1, 5, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 1, 1, 5};
    tbl[14] = '{0, 0, 1, 1, 1, 6};
    tbl[15] = '{0, 0, 1, 1, 1, 7};

    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_level", queue_level, 3'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);

    rst_n = 1'b1;
    for (int w = 0; w < IMEM_WORDS; w++) load_word(w, 32'h1000_0000 + w);

    for (int i = 0; i < 16; i++) begin
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      inst_ready  = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_level", i), queue_level, tbl[i].elvl);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_inst", i), inst_out, 32'h1000_0000 + (tbl[i].epc % 32));
      end
    end
    redirect = 1'b0;

    // Wrap past the end of memory while streaming.
    redirect = 1'b1; redirect_pc = 32'd30; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_gap", inst_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wrap%0d_pc", k), inst_pc, 32'd30 + k);
      chk($sformatf("wrap%0d_inst", k), inst_out, 32'h1000_0000 + ((30 + k) % 32));
    end

    // Rewrite word 0 mid-stream.
    load_word(0, 32'hCAFE_F00D);
    chk("load_flush_valid", inst_valid, 1'b0);
    chk("load_flush_level", queue_level, 3'd0);
    tick();
    chk("load_gap", inst_valid, 1'b0);
    tick();
    chk("load_valid", inst_valid, 1'b1);
    chk("load_pc", inst_pc, 32'd0);
    chk("load_inst", inst_out, 32'hCAFE_F00D);

    // Asynchronous reset with a full queue.
    inst_ready = 1'b0;
    repeat (6) tick();
    chk("full_level", queue_level, 3'd4);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_level", queue_level, 3'd0);
    chk("arst_inst", inst_out, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("arst_gap", inst_valid, 1'b0);
    tick();
    chk("arst_pc", inst_pc, 32'd0);
    chk("arst_inst0", inst_out, 32'hCAFE_F00D);
    tick();
    chk("arst_pc1", inst_pc, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      load_we     = ($urandom_range(0, 49) == 0);
      load_addr   = 7'($urandom_range(0, 127));
      load_data   = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_prefetch.md
# inst_prefetch

Parametrised instruction-fetch front end for the pipelined core. It combines byte-loadable synchronous instruction memory, a word-addressed program counter and a prefetch queue with a valid/ready output. It sits between the program-load port and the IF/ID register. Compared with the current fetch path, it adds configurable instruction width, memory depth and queue depth, decoupled backpressure and single-cycle redirect flush.

## Interface
Parameters:
- XLEN, 32: instruction width in bits; must be a multiple of 8.
- IMEM_WORDS, 32: instruction memory depth in words; must be a power of 2.
- QDEPTH, 4: prefetch queue entries; must be a power of 2 and at least 4.
- PC_W, 32: program counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- load_addr, input, log2(IMEM_WORDS*XLEN/8): byte address for program loading.
- load_data, input, 8: byte to write.
- load_we, input, 1: byte write strobe.
- redirect, input, 1: branch/jump taken; flushes the queue.
- redirect_pc, input, PC_W: new fetch PC.
- inst_valid, output, 1: queue head is valid.
- inst_ready, input, 1: consumer accepts the head this cycle.
- inst_out, output, XLEN: instruction at the queue head.
- inst_pc, output, PC_W: PC of inst_out.
- queue_level, output, log2(QDEPTH)+1: number of occupied entries.

## Operation
- Memory: IMEM_WORDS x XLEN, synchronous read with 1-cycle latency.
  - Word index = pc mod IMEM_WORDS; PC increments by 1 per instruction and wraps at 2^PC_W.
  - A load_we write targets word load_addr / (XLEN/8), byte lane load_addr mod (XLEN/8), little-endian.
  - Read and write to the same word in one cycle: the read returns the old data.
- State:
  - fetch_pc.
  - rd_valid and rd_pc, for the one in-flight read.
  - Circular queue of {inst, pc} with head pointer, tail pointer and count.
- Issue rule: a read of fetch_pc is issued when all of the following hold:
  - load_we = 0,
  - redirect = 0,
  - count + rd_valid < QDEPTH.
  - On issue: rd_valid <= 1, rd_pc <= fetch_pc, fetch_pc <= fetch_pc + 1.
  - Otherwise rd_valid <= 0.
- Push: when rd_valid = 1 and no redirect/load_we this cycle, {memory data, rd_pc} is written at tail.
- Pop: when inst_valid and inst_ready, head advances.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Outputs: inst_valid = (count != 0); inst_out and inst_pc come from the head entry; queue_level = count.
- Redirect (priority over push and pop):
  - count, head and tail <= 0; rd_valid <= 0, which discards the in-flight read.
  - fetch_pc <= redirect_pc.
  - Any pop that cycle is ignored.
- load_we:
  - Same flush as redirect, except fetch_pc <= 0.
  - If redirect and load_we are both high, load_we wins and fetch_pc <= 0.
- Reset, asynchronous and allowed at any time including mid-stream:
  - fetch_pc = 0, rd_valid = 0, count = head = tail = 0.
  - inst_valid = 0, queue_level = 0, inst_out = 0, inst_pc = 0.
  - Memory contents are not reset.

## Timing
- Edge numbering:
  - E0 is the first rising edge with rst_n high.
  - Rf is the edge that samples redirect.
  - L is the edge that samples the last load_we.
- From reset: read of PC 0 issues at E0; push at E1; inst_valid = 1 after E1 with inst_pc = 0.
- Redirect: first instruction from redirect_pc is valid 2 edges after Rf; inst_valid = 0 for the cycle after Rf.
- After load_we deasserts: PC 0 is valid 2 edges after L.
- Throughput: with inst_ready held high, one instruction per cycle after the first, with no bubbles.
- Backpressure: the credit check guarantees no overflow. count never exceeds QDEPTH, and no issued read is ever dropped except by flush.
- Queue pointers wrap modulo QDEPTH.

## Test plan
- Load and stream: load words 0..7 = 0x1000_0000+i byte-wise, hold inst_ready = 1 → inst_valid rises after E1; outputs (pc 0, 0x10000000), (pc 1, 0x10000001), … on consecutive cycles.
- Backpressure: inst_ready = 0 from reset → queue_level saturates at exactly 4 and stays there; releasing inst_ready yields pcs 0,1,2,3,4,… in order with no duplicates or gaps.
- Redirect mid-stream: pulse redirect with redirect_pc = 5 while queue_level = 3 → next cycle inst_valid = 0 and queue_level = 0; two edges after the redirect edge, inst_pc = 5, followed by 6.
- Wrap: redirect to PC 30 with IMEM_WORDS = 32 → pcs 30, 31, 32, 33 carry memory words 30, 31, 0, 1.
- Load during run: assert load_we mid-stream to rewrite word 0 → queue flushes; after release, PC 0 returns the new word.
- Reset mid-operation: drop rst_n asynchronously with a full queue → inst_valid and queue_level go to 0 immediately without waiting for a clock edge; after release, the sequence restarts at PC 0 with memory contents preserved.
